// File: rtl/mux_rr_arb.sv
// N-channel registered multiplexer with valid/ready inputs and a round-robin or
// fixed-priority arbiter choosing which channel feeds the single output register.
module mux_rr_arb #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    // Handshake: a word moves on channel i in any cycle where in_valid[i] and
    // in_ready[i] are both high; the output word is consumed when out_valid and
    // out_ready are both high. in_ready never depends on in_data.

    logic [SW-1:0] ptr;
    logic [SW-1:0] base;
    logic [SW-1:0] idx;
    logic [SW-1:0] gidx;
    logic [N-1:0]  grant;
    logic          any;
    logic          load;
    logic [W-1:0]  chan_data [N];

    for (genvar i = 0; i < N; i++) begin : g_split
        assign chan_data[i] = in_data[i*W +: W];
    end

    assign load = !out_valid || out_ready;
    assign base = (MODE == 1) ? '0 : ptr;

    // Scan channels starting at base; the first requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = SW'((int'(base) + k) % N);
            if (!any && in_valid[idx]) begin
                any         = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    // Gated by rst_n so nothing is offered as taken while reset is held.
    assign in_ready = (rst_n && load) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= chan_data[gidx];
                out_chan  <= gidx;
                if (MODE == 0) begin
                    ptr <= (gidx == SW'(N - 1)) ? '0 : gidx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
